// File: rtl/pipe_ctrl.sv
// pipe_ctrl: RV32I decode plus ID/EX, EX/MEM, MEM/WB control pipeline, EX branch resolution and hazard/forwarding control.
// Decode in ID reaches EX +1, MEM +2, WB +3 cycles; hazards hold PC/IF-ID and bubble ID/EX, a taken redirect overrides any stall.
module pipe_ctrl #(
  parameter bit FWD_EN   = 1'b1,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instr_d_i,
  input  logic                instr_valid_i,
  input  logic                br_less_i,
  input  logic                br_equal_i,
  output logic                br_unsigned_o,
  output logic                br_sel_o,
  output logic                stall_f_o,
  output logic                stall_d_o,
  output logic                flush_d_o,
  output logic                flush_e_o,
  output logic                op_a_sel_e_o,
  output logic                op_b_sel_e_o,
  output logic [ALU_OP_W-1:0] alu_op_e_o,
  output logic [1:0]          fwd_a_o,
  output logic [1:0]          fwd_b_o,
  output logic                mem_wren_m_o,
  output logic                rd_wren_w_o,
  output logic [1:0]          wb_sel_w_o,
  output logic [4:0]          rd_addr_w_o,
  output logic                illegal_e_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);

  typedef struct packed {
    logic                rd_wren;
    logic                mem_wren;
    logic [1:0]          wb_sel;
    logic                op_a_sel;
    logic                op_b_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                is_branch;
    logic                is_jump;
    logic                is_load;
    logic                illegal;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
  } ex_ctrl_t;

  typedef struct packed {
    logic       rd_wren;
    logic       mem_wren;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic       rd_wren;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  dec, ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  logic      use_rs1, use_rs2;
  logic      br_taken, load_use, raw_stall, hazard;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d_i[31], instr_d_i[29:25]};

  // funct3 -> ALU op; alt selects SUB/SRA.
  function automatic logic [ALU_OP_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_OP_W'(1) : ALU_OP_W'(0);
      3'b001:  alu_fn = ALU_OP_W'(2);
      3'b010:  alu_fn = ALU_OP_W'(3);
      3'b011:  alu_fn = ALU_OP_W'(4);
      3'b100:  alu_fn = ALU_OP_W'(5);
      3'b101:  alu_fn = alt ? ALU_OP_W'(7) : ALU_OP_W'(6);
      3'b110:  alu_fn = ALU_OP_W'(8);
      default: alu_fn = ALU_OP_W'(9);
    endcase
  endfunction

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (instr_valid_i) begin
      case (instr_d_i[6:0])
        OP_R: begin
          dec.rd_wren = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
          dec.alu_op  = alu_fn(instr_d_i[14:12], instr_d_i[30]);
        end
        OP_I: begin
          dec.rd_wren = 1'b1; dec.op_b_sel = 1'b1; use_rs1 = 1'b1;
          dec.alu_op  = alu_fn(instr_d_i[14:12], (instr_d_i[14:12] == 3'b101) && instr_d_i[30]);
        end
        OP_LOAD: begin
          dec.rd_wren = 1'b1; dec.is_load = 1'b1; dec.wb_sel = 2'b01;
          dec.op_b_sel = 1'b1; use_rs1 = 1'b1; dec.alu_op = ALU_ADD;
        end
        OP_STORE: begin
          dec.mem_wren = 1'b1; dec.op_b_sel = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
          dec.alu_op   = ALU_ADD;
        end
        OP_BRANCH: begin
          dec.is_branch = 1'b1; dec.funct3 = instr_d_i[14:12];
          dec.op_a_sel  = 1'b1; dec.op_b_sel = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
          dec.alu_op    = ALU_ADD;
        end
        OP_JAL: begin
          dec.rd_wren = 1'b1; dec.is_jump = 1'b1; dec.wb_sel = 2'b10;
          dec.op_a_sel = 1'b1; dec.op_b_sel = 1'b1; dec.alu_op = ALU_ADD;
        end
        OP_JALR: begin
          dec.rd_wren = 1'b1; dec.is_jump = 1'b1; dec.wb_sel = 2'b10;
          dec.op_b_sel = 1'b1; use_rs1 = 1'b1; dec.alu_op = ALU_ADD;
        end
        OP_LUI: begin
          dec.rd_wren = 1'b1; dec.op_b_sel = 1'b1; dec.alu_op = ALU_PASS_B;
        end
        OP_AUIPC: begin
          dec.rd_wren = 1'b1; dec.op_a_sel = 1'b1; dec.op_b_sel = 1'b1; dec.alu_op = ALU_ADD;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    // Unused or x0 register fields are zeroed so they can never match in hazard/forward compares.
    dec.rd_wren = dec.rd_wren && (instr_d_i[11:7] != 5'd0);
    dec.rd      = dec.rd_wren ? instr_d_i[11:7] : 5'd0;
    dec.rs1     = use_rs1 ? instr_d_i[19:15] : 5'd0;
    dec.rs2     = use_rs2 ? instr_d_i[24:20] : 5'd0;
  end

  always_comb begin
    br_taken = ex_q.is_jump;
    if (ex_q.is_branch) begin
      case (ex_q.funct3)
        3'b000:         br_taken = br_equal_i;
        3'b001:         br_taken = !br_equal_i;
        3'b100, 3'b110: br_taken = br_less_i;
        3'b101, 3'b111: br_taken = !br_less_i;
        default:        br_taken = 1'b0;
      endcase
    end
  end

  assign load_use  = ex_q.is_load && ex_q.rd_wren &&
                     ((dec.rs1 == ex_q.rd) || (dec.rs2 == ex_q.rd));
  assign raw_stall = (ex_q.rd_wren  && ((dec.rs1 == ex_q.rd)  || (dec.rs2 == ex_q.rd))) ||
                     (mem_q.rd_wren && ((dec.rs1 == mem_q.rd) || (dec.rs2 == mem_q.rd)));
  assign hazard    = FWD_EN ? load_use : raw_stall;

  assign br_sel_o      = br_taken;
  assign br_unsigned_o = ex_q.is_branch && ex_q.funct3[1];
  assign stall_f_o     = hazard && !br_taken;
  assign stall_d_o     = hazard && !br_taken;
  assign flush_d_o     = br_taken;
  assign flush_e_o     = br_taken || hazard;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input mem_ctrl_t m, input wb_ctrl_t w);
    fwd_sel = 2'b00;
    if (FWD_EN && rs != 5'd0) begin
      if (m.rd_wren && m.rd == rs)      fwd_sel = 2'b01;
      else if (w.rd_wren && w.rd == rs) fwd_sel = 2'b10;
    end
  endfunction

  assign fwd_a_o = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign fwd_b_o = fwd_sel(ex_q.rs2, mem_q, wb_q);

  assign op_a_sel_e_o = ex_q.op_a_sel;
  assign op_b_sel_e_o = ex_q.op_b_sel;
  assign alu_op_e_o   = ex_q.alu_op;
  assign illegal_e_o  = ex_q.illegal;
  assign mem_wren_m_o = mem_q.mem_wren;
  assign rd_wren_w_o  = wb_q.rd_wren;
  assign wb_sel_w_o   = wb_q.wb_sel;
  assign rd_addr_w_o  = wb_q.rd;

  // ID/EX never holds: a stall always pairs with a bubble, so only the front end freezes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= flush_e_o ? '0 : dec;
      mem_q <= '{rd_wren: ex_q.rd_wren, mem_wren: ex_q.mem_wren, wb_sel: ex_q.wb_sel, rd: ex_q.rd};
      wb_q  <= '{rd_wren: mem_q.rd_wren, wb_sel: mem_q.wb_sel, rd: mem_q.rd};
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one forwarding instance and one stall-only instance share the stimulus.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        vld = 1'b0, br_less = 1'b0, br_equal = 1'b0;

  logic       br_uns_f, br_sel_f, stall_f_f, stall_d_f, flush_d_f, flush_e_f, op_a_f, op_b_f;
  logic [3:0] alu_f;
  logic [1:0] fwd_a_f, fwd_b_f, wb_sel_f;
  logic       mem_wren_f, rd_wren_f, illegal_f;
  logic [4:0] rd_addr_f;

  logic       br_uns_n, br_sel_n, stall_f_n, stall_d_n, flush_d_n, flush_e_n, op_a_n, op_b_n;
  logic [3:0] alu_n;
  logic [1:0] fwd_a_n, fwd_b_n, wb_sel_n;
  logic       mem_wren_n, rd_wren_n, illegal_n;
  logic [4:0] rd_addr_n;

  logic [25:0] outs_f, outs_n;
  assign outs_f = {br_uns_f, br_sel_f, stall_f_f, stall_d_f, flush_d_f, flush_e_f, op_a_f, op_b_f,
                   alu_f, fwd_a_f, fwd_b_f, mem_wren_f, rd_wren_f, wb_sel_f, rd_addr_f, illegal_f};
  assign outs_n = {br_uns_n, br_sel_n, stall_f_n, stall_d_n, flush_d_n, flush_e_n, op_a_n, op_b_n,
                   alu_n, fwd_a_n, fwd_b_n, mem_wren_n, rd_wren_n, wb_sel_n, rd_addr_n, illegal_n};

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.FWD_EN(1'b1), .ALU_OP_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .instr_d_i(instr), .instr_valid_i(vld),
    .br_less_i(br_less), .br_equal_i(br_equal),
    .br_unsigned_o(br_uns_f), .br_sel_o(br_sel_f), .stall_f_o(stall_f_f), .stall_d_o(stall_d_f),
    .flush_d_o(flush_d_f), .flush_e_o(flush_e_f), .op_a_sel_e_o(op_a_f), .op_b_sel_e_o(op_b_f),
    .alu_op_e_o(alu_f), .fwd_a_o(fwd_a_f), .fwd_b_o(fwd_b_f), .mem_wren_m_o(mem_wren_f),
    .rd_wren_w_o(rd_wren_f), .wb_sel_w_o(wb_sel_f), .rd_addr_w_o(rd_addr_f), .illegal_e_o(illegal_f));

  pipe_ctrl #(.FWD_EN(1'b0), .ALU_OP_W(4)) dut_nf (
    .clk_i(clk), .rst_i(rst), .instr_d_i(instr), .instr_valid_i(vld),
    .br_less_i(br_less), .br_equal_i(br_equal),
    .br_unsigned_o(br_uns_n), .br_sel_o(br_sel_n), .stall_f_o(stall_f_n), .stall_d_o(stall_d_n),
    .flush_d_o(flush_d_n), .flush_e_o(flush_e_n), .op_a_sel_e_o(op_a_n), .op_b_sel_e_o(op_b_n),
    .alu_op_e_o(alu_n), .fwd_a_o(fwd_a_n), .fwd_b_o(fwd_b_n), .mem_wren_m_o(mem_wren_n),
    .rd_wren_w_o(rd_wren_n), .wb_sel_w_o(wb_sel_n), .rd_addr_w_o(rd_addr_n), .illegal_e_o(illegal_n));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vld = 1'b0; instr = 32'd0; br_less = 1'b0; br_equal = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b1; instr = 32'hFFFF_FFFF;
    tick(); tick();
    checks++; if (outs_f !== 26'd0) begin errors++; $display("FAIL reset_outs_fwd: got %h want 0", outs_f); end
    checks++; if (outs_n !== 26'd0) begin errors++; $display("FAIL reset_outs_nofwd: got %h want 0", outs_n); end
    rst = 1'b0; vld = 1'b0;
    tick();
  endtask

  task automatic test_add();
    instr = 32'h00A9_8933; vld = 1'b1;
    tick();
    vld = 1'b0; #1;
    checks++; if ({alu_f, op_a_f, op_b_f} !== 6'b0000_00) begin errors++; $display("FAIL add_ex_ctrl: got %b want 000000", {alu_f, op_a_f, op_b_f}); end
    tick(); tick();
    checks++; if ({rd_wren_f, rd_addr_f, wb_sel_f} !== {1'b1, 5'd18, 2'b00}) begin errors++; $display("FAIL add_wb: got %b want %b", {rd_wren_f, rd_addr_f, wb_sel_f}, {1'b1, 5'd18, 2'b00}); end
    drain();
  endtask

  task automatic test_decode();
    logic [31:0] ti [6];
    logic [5:0]  te [6];
    ti[0] = 32'h4031_00B3; te[0] = {4'd1,  2'b00};  // sub
    ti[1] = 32'h4031_5093; te[1] = {4'd7,  2'b01};  // srai
    ti[2] = 32'h4001_0093; te[2] = {4'd0,  2'b01};  // addi imm=1024, bit30 ignored
    ti[3] = 32'h1234_52B7; te[3] = {4'd10, 2'b01};  // lui
    ti[4] = 32'h0000_1097; te[4] = {4'd0,  2'b11};  // auipc
    ti[5] = 32'h0062_B233; te[5] = {4'd4,  2'b00};  // sltu
    for (int k = 0; k < 6; k++) begin
      instr = ti[k]; vld = 1'b1;
      tick();
      checks++; if ({alu_f, op_a_f, op_b_f} !== te[k]) begin errors++; $display("FAIL decode_%0d: got %b want %b", k, {alu_f, op_a_f, op_b_f}, te[k]); end
    end
    drain();
  endtask

  task automatic test_load_use();
    instr = 32'h0081_2703; vld = 1'b1; #1;
    checks++; if (stall_d_f !== 1'b0) begin errors++; $display("FAIL lu_pre_stall: got %b want 0", stall_d_f); end
    tick();
    instr = 32'h0017_02B3; #1;
    checks++; if ({stall_f_f, stall_d_f, flush_e_f, flush_d_f} !== 4'b1110) begin errors++; $display("FAIL lu_stall: got %b want 1110", {stall_f_f, stall_d_f, flush_e_f, flush_d_f}); end
    tick();
    checks++; if ({stall_f_f, stall_d_f, flush_e_f, flush_d_f} !== 4'b0000) begin errors++; $display("FAIL lu_stall_once: got %b want 0000", {stall_f_f, stall_d_f, flush_e_f, flush_d_f}); end
    tick();
    vld = 1'b0; #1;
    checks++; if ({fwd_a_f, fwd_b_f} !== 4'b1000) begin errors++; $display("FAIL lu_fwd: got %b want 1000", {fwd_a_f, fwd_b_f}); end
    drain();
  endtask

  task automatic test_branch();
    instr = 32'h0021_C463; vld = 1'b1;
    tick();
    vld = 1'b0; br_less = 1'b1; #1;
    checks++; if ({br_sel_f, br_uns_f, flush_d_f, flush_e_f, stall_f_f} !== 5'b10110) begin errors++; $display("FAIL blt_taken: got %b want 10110", {br_sel_f, br_uns_f, flush_d_f, flush_e_f, stall_f_f}); end
    tick();
    checks++; if (br_sel_f !== 1'b0) begin errors++; $display("FAIL blt_bubble: got %b want 0", br_sel_f); end
    instr = 32'h0021_E463; vld = 1'b1; br_less = 1'b0;
    tick();
    vld = 1'b0; #1;
    checks++; if ({br_sel_f, br_uns_f, flush_d_f, flush_e_f} !== 4'b0100) begin errors++; $display("FAIL bltu_not_taken: got %b want 0100", {br_sel_f, br_uns_f, flush_d_f, flush_e_f}); end
    drain();
  endtask

  task automatic test_forward();
    instr = 32'h0050_0093; vld = 1'b1;
    tick();
    instr = 32'h0010_8093; #1;
    checks++; if (stall_d_f !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b want 0", stall_d_f); end
    tick();
    instr = 32'h0010_8133; #1;
    checks++; if ({fwd_a_f, fwd_b_f} !== 4'b0100) begin errors++; $display("FAIL fwd_addi: got %b want 0100", {fwd_a_f, fwd_b_f}); end
    tick();
    vld = 1'b0; #1;
    checks++; if ({fwd_a_f, fwd_b_f} !== 4'b0101) begin errors++; $display("FAIL fwd_mem_prio: got %b want 0101", {fwd_a_f, fwd_b_f}); end
    drain();
    instr = 32'h0050_8013; vld = 1'b1;  // addi x0,x1,5
    tick();
    instr = 32'h0000_01B3;              // add x3,x0,x0
    tick();
    vld = 1'b0; #1;
    checks++; if ({fwd_a_f, fwd_b_f} !== 4'b0000) begin errors++; $display("FAIL fwd_x0: got %b want 0000", {fwd_a_f, fwd_b_f}); end
    tick();
    checks++; if ({rd_wren_f, rd_addr_f} !== 6'd0) begin errors++; $display("FAIL x0_no_write: got %b want 0", {rd_wren_f, rd_addr_f}); end
    drain();
  endtask

  task automatic test_illegal();
    instr = 32'hFFFF_FFFF; vld = 1'b1;
    tick();
    vld = 1'b0; #1;
    checks++; if (illegal_f !== 1'b1) begin errors++; $display("FAIL illegal_ex: got %b want 1", illegal_f); end
    tick();
    checks++; if ({illegal_f, mem_wren_f} !== 2'b00) begin errors++; $display("FAIL illegal_mem: got %b want 00", {illegal_f, mem_wren_f}); end
    tick();
    checks++; if ({rd_wren_f, wb_sel_f} !== 3'b000) begin errors++; $display("FAIL illegal_wb: got %b want 000", {rd_wren_f, wb_sel_f}); end
    instr = 32'h0011_2223; vld = 1'b1;  // sw x1,4(x2)
    tick();
    vld = 1'b0;
    tick();
    checks++; if (mem_wren_f !== 1'b1) begin errors++; $display("FAIL sw_mem_wren: got %b want 1", mem_wren_f); end
    tick();
    checks++; if ({rd_wren_f, rd_addr_f} !== 6'd0) begin errors++; $display("FAIL sw_no_rd: got %b want 0", {rd_wren_f, rd_addr_f}); end
    drain();
  endtask

  task automatic test_no_fwd();
    rst = 1'b1; tick(); rst = 1'b0;
    instr = 32'h0050_0093; vld = 1'b1; #1;
    checks++; if ({stall_f_n, stall_d_n, flush_e_n} !== 3'b000) begin errors++; $display("FAIL nf_pre: got %b want 000", {stall_f_n, stall_d_n, flush_e_n}); end
    tick();
    instr = 32'h0000_8133; #1;
    checks++; if ({stall_f_n, stall_d_n, flush_e_n} !== 3'b111) begin errors++; $display("FAIL nf_stall_ex: got %b want 111", {stall_f_n, stall_d_n, flush_e_n}); end
    tick();
    checks++; if ({stall_f_n, stall_d_n, flush_e_n} !== 3'b111) begin errors++; $display("FAIL nf_stall_mem: got %b want 111", {stall_f_n, stall_d_n, flush_e_n}); end
    tick();
    checks++; if ({stall_f_n, stall_d_n, flush_e_n} !== 3'b000) begin errors++; $display("FAIL nf_release: got %b want 000", {stall_f_n, stall_d_n, flush_e_n}); end
    tick();
    vld = 1'b0; #1;
    checks++; if ({fwd_a_n, fwd_b_n, alu_n} !== 8'd0) begin errors++; $display("FAIL nf_fwd: got %b want 0", {fwd_a_n, fwd_b_n, alu_n}); end
    drain();
    instr = 32'h0050_0093; vld = 1'b1;
    tick();
    instr = 32'h0000_8133; #1;
    checks++; if (stall_d_n !== 1'b1) begin errors++; $display("FAIL nf_stall_before_rst: got %b want 1", stall_d_n); end
    rst = 1'b1;
    tick();
    checks++; if (outs_n !== 26'd0) begin errors++; $display("FAIL nf_rst_mid: got %h want 0", outs_n); end
    checks++; if (outs_f !== 26'd0) begin errors++; $display("FAIL fwd_rst_mid: got %h want 0", outs_f); end
    rst = 1'b0;
    instr = 32'h0100_00EF; vld = 1'b1;  // jal x1,16
    tick();
    instr = 32'h0000_8133; #1;          // add x2,x1,x0 hazards on jal's rd
    checks++; if ({br_sel_n, stall_f_n, stall_d_n, flush_d_n, flush_e_n} !== 5'b10011) begin errors++; $display("FAIL nf_flush_wins: got %b want 10011", {br_sel_n, stall_f_n, stall_d_n, flush_d_n, flush_e_n}); end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_load_use();
    test_branch();
    test_forward();
    test_illegal();
    test_no_fwd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle RV32I control unit. Decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches in EX, detects load-use and RAW hazards, and drives the forwarding muxes and the stall/flush controls for the 5-stage core.

Parameters:
- FWD_EN, 1, 1 = EX-stage forwarding enabled; 0 = no forwarding, resolve every RAW hazard by stalling.
- ALU_OP_W, 4, width of alu_op; encodings below must fit.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_d_i  in  32  instruction currently in ID
- instr_valid_i  in  1  ID holds a valid instruction
- br_less_i  in  1  EX comparator: rs1 < rs2 (signed/unsigned per br_unsigned_o)
- br_equal_i  in  1  EX comparator: rs1 == rs2
- br_unsigned_o  out  1  EX comparator mode (funct3[1] of EX branch)
- br_sel_o  out  1  EX redirect: branch taken, JAL or JALR
- stall_f_o, stall_d_o  out  1  hold PC / IF-ID register
- flush_d_o, flush_e_o  out  1  squash IF-ID / insert bubble into ID-EX
- op_a_sel_e_o  out  1  1 = PC, 0 = rs1
- op_b_sel_e_o  out  1  1 = imm, 0 = rs2
- alu_op_e_o  out  ALU_OP_W  ALU operation in EX
- fwd_a_o, fwd_b_o  out  2  00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result
- mem_wren_m_o  out  1  store enable in MEM
- rd_wren_w_o  out  1  regfile write enable in WB
- wb_sel_w_o  out  2  00 = ALU, 01 = load data, 10 = PC+4
- rd_addr_w_o  out  5  regfile write address
- illegal_e_o  out  1  EX holds an undecodable instruction (one cycle per instruction)

Behaviour:
- Decode (ID, combinational) covers R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Any other opcode, or instr_valid_i = 0, produces a bubble: all write enables 0 and br_sel 0. An unknown opcode with valid = 1 additionally sets the illegal bit.
- alu_op encodings: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASS_B 1010 (LUI).
  - SUB/SRA are selected by instr[30]; for I-type only SRAI uses instr[30].
  - LOAD, STORE, AUIPC, JAL and JALR use ADD.
- Stage registers update every cycle unless stalled. Latency: decode in cycle N drives EX outputs in N+1, MEM in N+2, WB in N+3.
- Reset: on rst_i = 1, all three stage registers load a bubble. Every output is 0 in the cycle after reset is sampled (fwd 00, wb_sel 00, rd_addr 0). Asserting reset mid-stream discards all in-flight instructions.
- Branch (EX): br_sel_o is taken per funct3 using br_equal_i/br_less_i:
  - BEQ eq, BNE !eq, BLT/BLTU lt, BGE/BGEU !lt.
  - JAL and JALR are always taken.
  - br_unsigned_o = funct3[1] for branches, 0 otherwise.
  - When taken: flush_d_o = flush_e_o = 1 in the same cycle, so the next EX is a bubble.
- Load-use (FWD_EN = 1): EX is a LOAD with rd != 0, and an ID source actually used by the ID opcode equals that rd.
  - Response: stall_f_o = stall_d_o = 1 and flush_e_o = 1, a one-cycle bubble.
  - rs2 counts as used only for R, STORE and BRANCH; rs1 for all except LUI, AUIPC and JAL.
- FWD_EN = 0: stall with a bubble while any used ID source matches a non-zero rd with rd_wren in EX or MEM. WB needs no stall because the regfile is write-through. fwd_a_o and fwd_b_o stay 00.
- Forwarding (FWD_EN = 1): applies to the EX sources.
  - 01 when MEM has rd_wren, rd != 0 and rd == rs.
  - Else 10 when WB has rd_wren, rd != 0 and rd == rs.
  - MEM has priority over WB. x0 is never forwarded.
- Simultaneous taken branch and hazard stall: the flush wins. stall_f_o and stall_d_o are forced to 0, because the ID instruction is squashed.
- rd_wren is forced to 0 when rd == 0.

Test Plan:
- Reset, then add x18,x19,x10 (0x00A98933) → three cycles later rd_wren_w_o = 1, rd_addr_w_o = 18, wb_sel_w_o = 00; in EX, alu_op = 0000, op_b_sel = 0.
- lw x14,8(x2) followed by add x5,x14,x1 → exactly one cycle of stall_f_o = stall_d_o = flush_e_o = 1. When the add reaches EX, fwd_a_o = 10.
- blt x3,x2 with br_less_i = 1 in EX → br_sel_o = 1, br_unsigned_o = 0, flush_d_o = flush_e_o = 1. Repeat as bltu with br_less_i = 0 → br_sel_o = 0, br_unsigned_o = 1, no flush.
- addi x1,x0,5; addi x1,x1,1; add x2,x1,x1 → the add sees fwd_a_o = fwd_b_o = 01 (MEM priority over WB). Writes to x0 are never forwarded.
- 0xFFFFFFFF → illegal_e_o = 1 for one cycle; mem_wren and rd_wren stay 0 through MEM and WB.
- FWD_EN = 0: addi x1,x0,5 then add x2,x1,x0 → 2 stall cycles. Asserting rst_i during a stall clears all outputs to 0 on the next edge.
